// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the 8-bit registered ALU.
// Accepts one operation per valid/ready handshake, drives and holds the ALU
// operands/INSTRUCT byte for the ALU pipeline latency, captures the result and
// returns it with zero/condition/error flags over a response handshake.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [3:0] REQ_OP,
  input  logic [1:0] REQ_IMM_SEL,
  input  logic [7:0] REQ_A,
  input  logic [7:0] REQ_B,
  input  logic [7:0] REQ_IMM,
  input  logic       REQ_CHAIN,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [7:0] ALU_IMM,
  output logic [7:0] ALU_INSTRUCT,
  input  logic [7:0] ALU_RESULT,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_RESULT,
  output logic       RSP_ZERO,
  output logic       RSP_COND,
  output logic       RSP_ERR
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_IMM_B = 2'b01;
  localparam logic [1:0] SEL_IMM_A = 2'b10;

  localparam logic [NIB_W-1:0] NIB_NONE  = 4'h0;
  localparam logic [NIB_W-1:0] NIB_IMM_B = 4'hD;
  localparam logic [NIB_W-1:0] NIB_IMM_A = 4'hE;

  localparam logic [OP_W-1:0] OP_CMP_9 = 4'h9;
  localparam logic [OP_W-1:0] OP_CMP_A = 4'hA;
  localparam logic [OP_W-1:0] OP_CMP_B = 4'hB;

  logic [1:0]        state_q,        state_d;
  logic [CNT_W-1:0]  cnt_q,          cnt_d;
  logic              req_ready_q,    req_ready_d;
  logic [DATA_W-1:0] alu_a_q,        alu_a_d;
  logic [DATA_W-1:0] alu_b_q,        alu_b_d;
  logic [DATA_W-1:0] alu_imm_q,      alu_imm_d;
  logic [DATA_W-1:0] alu_instruct_q, alu_instruct_d;
  logic              rsp_valid_q,    rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q,   rsp_result_d;
  logic              rsp_zero_q,     rsp_zero_d;
  logic              rsp_cond_q,     rsp_cond_d;
  logic              rsp_err_q,      rsp_err_d;
  logic [DATA_W-1:0] last_result_q,  last_result_d;

  logic              accept;
  logic              sel_illegal;
  logic [NIB_W-1:0]  imm_nib;
  logic [OP_W-1:0]   issued_op;
  logic              issued_is_cmp;

  // Handshake qualification: ready is only ever high while idle.
  assign accept      = REQ_VALID & req_ready_q;
  assign sel_illegal = (REQ_IMM_SEL == 2'b11);

  // Immediate-select encoding for the low INSTRUCT nibble.
  always_comb begin
    imm_nib = NIB_NONE;
    case (REQ_IMM_SEL)
      SEL_NONE:  imm_nib = NIB_NONE;
      SEL_IMM_B: imm_nib = NIB_IMM_B;
      SEL_IMM_A: imm_nib = NIB_IMM_A;
      default:   imm_nib = NIB_NONE;
    endcase
  end

  // Compare ops report their boolean in result bit 0.
  assign issued_op     = alu_instruct_q[DATA_W-1:NIB_W];
  assign issued_is_cmp = (issued_op == OP_CMP_9) || (issued_op == OP_CMP_A) ||
                         (issued_op == OP_CMP_B);

  // Next-state and datapath next values; every register holds by default.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_imm_d      = alu_imm_q;
    alu_instruct_d = alu_instruct_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_cond_d     = rsp_cond_q;
    rsp_err_d      = rsp_err_q;
    last_result_d  = last_result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (sel_illegal) begin
            // Illegal select never reaches the ALU; answer immediately.
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
            rsp_cond_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end else begin
            alu_a_d        = REQ_CHAIN ? last_result_q : REQ_A;
            alu_b_d        = REQ_B;
            alu_imm_d      = REQ_IMM;
            alu_instruct_d = {REQ_OP, imm_nib};
            cnt_d          = CNT_W'(ALU_LAT);
            state_d        = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // One cycle for the ALU to sample plus ALU_LAT cycles of pipeline.
        if (cnt_q == '0) begin
          rsp_result_d  = ALU_RESULT;
          rsp_zero_d    = (ALU_RESULT == '0);
          rsp_cond_d    = issued_is_cmp & ALU_RESULT[0];
          rsp_err_d     = 1'b0;
          last_result_d = ALU_RESULT;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (RSP_READY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  assign req_ready_d = (state_d == S_IDLE);
  assign rsp_valid_d = (state_d == S_RESP);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and handshake registers; reset drops any in-flight operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q          <= '0;
      req_ready_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_imm_q      <= '0;
      alu_instruct_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_cond_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
      last_result_q  <= '0;
    end else begin
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_imm_q      <= alu_imm_d;
      alu_instruct_q <= alu_instruct_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_cond_q     <= rsp_cond_d;
      rsp_err_q      <= rsp_err_d;
      last_result_q  <= last_result_d;
    end
  end

  assign REQ_READY    = req_ready_q;
  assign ALU_A        = alu_a_q;
  assign ALU_B        = alu_b_q;
  assign ALU_IMM      = alu_imm_q;
  assign ALU_INSTRUCT = alu_instruct_q;
  assign RSP_VALID    = rsp_valid_q;
  assign RSP_RESULT   = rsp_result_q;
  assign RSP_ZERO     = rsp_zero_q;
  assign RSP_COND     = rsp_cond_q;
  assign RSP_ERR      = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural single-stage ALU.
module tb_alu_issue_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [3:0] REQ_OP = 4'h0;
  logic [1:0] REQ_IMM_SEL = 2'b00;
  logic [7:0] REQ_A = 8'h00;
  logic [7:0] REQ_B = 8'h00;
  logic [7:0] REQ_IMM = 8'h00;
  logic       REQ_CHAIN = 1'b0;
  logic [7:0] ALU_A, ALU_B, ALU_IMM, ALU_INSTRUCT;
  logic [7:0] ALU_RESULT = 8'h00;
  logic       RSP_VALID;
  logic       RSP_READY = 1'b0;
  logic [7:0] RSP_RESULT;
  logic       RSP_ZERO, RSP_COND, RSP_ERR;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_issue_ctrl #(.ALU_LAT(1)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_IMM_SEL(REQ_IMM_SEL), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_IMM(REQ_IMM), .REQ_CHAIN(REQ_CHAIN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_IMM(ALU_IMM),
    .ALU_INSTRUCT(ALU_INSTRUCT), .ALU_RESULT(ALU_RESULT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RESULT(RSP_RESULT),
    .RSP_ZERO(RSP_ZERO), .RSP_COND(RSP_COND), .RSP_ERR(RSP_ERR)
  );

  // Stand-in ALU: add/sub/mul/eq/gt/lt, immediate substitution by nibble.
  function automatic logic [7:0] alu_f(input logic [7:0] instr, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] imm);
    logic [7:0] ea, eb;
    logic [15:0] prod;
    ea = (instr[3:0] == 4'hE) ? imm : a;
    eb = (instr[3:0] == 4'hD) ? imm : b;
    prod = ea * eb;
    case (instr[7:4])
      4'h0: return ea + eb;
      4'h1: return ea - eb;
      4'h2: return prod[7:0];
      4'h9: return {7'd0, ea == eb};
      4'hA: return {7'd0, ea > eb};
      4'hB: return {7'd0, ea < eb};
      default: return 8'h00;
    endcase
  endfunction

  // One-edge registered ALU.
  always @(posedge CLK) ALU_RESULT <= alu_f(ALU_INSTRUCT, ALU_A, ALU_B, ALU_IMM);

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request, wait (bounded) for ready, take the accept edge.
  task automatic send_req(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] imm, input logic chain);
    REQ_OP = op; REQ_IMM_SEL = sel; REQ_A = a; REQ_B = b; REQ_IMM = imm;
    REQ_CHAIN = chain; REQ_VALID = 1'b1;
    for (int i = 0; i < 20 && !REQ_READY; i++) tick;
    check("req_ready", 32'(REQ_READY), 32'd1);
    tick;
    REQ_VALID = 1'b0;
    REQ_CHAIN = 1'b0;
  endtask

  // Count edges after the accept edge until a response appears (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 20 && !RSP_VALID; i++) begin
      tick;
      lat++;
    end
    check("rsp_valid", 32'(RSP_VALID), 32'd1);
  endtask

  task automatic release_rsp;
    RSP_READY = 1'b1;
    tick;
    RSP_READY = 1'b0;
    check("rsp_drop", 32'(RSP_VALID), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [1:0] sel,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                        input logic chain, input logic [7:0] exp_a, input logic [7:0] exp_instr,
                        input logic [7:0] exp_res, input logic exp_zero, input logic exp_cond);
    int lat;
    send_req(op, sel, a, b, imm, chain);
    check({tag, "_instr"}, 32'(ALU_INSTRUCT), 32'(exp_instr));
    check({tag, "_alu_a"}, 32'(ALU_A), 32'(exp_a));
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_res"}, 32'(RSP_RESULT), 32'(exp_res));
    check({tag, "_zero"}, 32'(RSP_ZERO), 32'(exp_zero));
    check({tag, "_cond"}, 32'(RSP_COND), 32'(exp_cond));
    check({tag, "_err"}, 32'(RSP_ERR), 32'd0);
    release_rsp;
  endtask

  initial begin
    int lat;

    // Reset state
    #3;
    check("rst_ready", 32'(REQ_READY), 32'd0);
    check("rst_valid", 32'(RSP_VALID), 32'd0);
    check("rst_instr", 32'(ALU_INSTRUCT), 32'd0);
    check("rst_result", 32'(RSP_RESULT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tick;
    check("idle_ready", 32'(REQ_READY), 32'd1);

    //       tag    op    sel    A      B      IMM    ch  expA   instr  res    z  c
    run_op("add",  4'h0, 2'b00, 8'h12, 8'h34, 8'h00, 0, 8'h12, 8'h00, 8'h46, 0, 0);
    run_op("subi", 4'h1, 2'b01, 8'h10, 8'h55, 8'h10, 0, 8'h10, 8'h1D, 8'h00, 1, 0);
    run_op("cmpa", 4'hA, 2'b00, 8'h05, 8'h03, 8'h00, 0, 8'h05, 8'hA0, 8'h01, 0, 1);
    run_op("cmp9", 4'h9, 2'b00, 8'h05, 8'h03, 8'h00, 0, 8'h05, 8'h90, 8'h00, 1, 0);
    run_op("ch0",  4'h0, 2'b00, 8'h01, 8'h01, 8'h00, 0, 8'h01, 8'h00, 8'h02, 0, 0);
    run_op("ch1",  4'h2, 2'b00, 8'hFF, 8'h03, 8'h00, 1, 8'h02, 8'h20, 8'h06, 0, 0);

    // Backpressure: response held while a new request waits
    send_req(4'h0, 2'b00, 8'h03, 8'h04, 8'h00, 1'b0);
    wait_rsp(lat);
    REQ_OP = 4'h1; REQ_IMM_SEL = 2'b00; REQ_A = 8'h09; REQ_B = 8'h02; REQ_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", 32'(RSP_VALID), 32'd1);
      check("bp_res", 32'(RSP_RESULT), 32'h07);
      check("bp_ready", 32'(REQ_READY), 32'd0);
      check("bp_instr", 32'(ALU_INSTRUCT), 32'h00);
    end
    RSP_READY = 1'b1;
    tick;
    RSP_READY = 1'b0;
    check("bp_drop", 32'(RSP_VALID), 32'd0);
    check("bp_idle", 32'(REQ_READY), 32'd1);
    check("bp_noissue", 32'(ALU_INSTRUCT), 32'h00);
    tick;
    REQ_VALID = 1'b0;
    check("bp_acc_ready", 32'(REQ_READY), 32'd0);
    check("bp_acc_instr", 32'(ALU_INSTRUCT), 32'h10);
    check("bp_acc_a", 32'(ALU_A), 32'h09);
    wait_rsp(lat);
    check("bp2_lat", 32'(lat), 32'd2);
    check("bp2_res", 32'(RSP_RESULT), 32'h07);
    release_rsp;

    // Illegal select: immediate error response, ALU untouched
    send_req(4'h3, 2'b11, 8'hAA, 8'hBB, 8'hCC, 1'b0);
    wait_rsp(lat);
    check("err_lat", 32'(lat), 32'd0);
    check("err_err", 32'(RSP_ERR), 32'd1);
    check("err_res", 32'(RSP_RESULT), 32'h00);
    check("err_zero", 32'(RSP_ZERO), 32'd1);
    check("err_cond", 32'(RSP_COND), 32'd0);
    check("err_instr", 32'(ALU_INSTRUCT), 32'h10);
    check("err_alu_a", 32'(ALU_A), 32'h09);
    release_rsp;
    run_op("errch", 4'h0, 2'b00, 8'hFF, 8'h01, 8'h00, 1, 8'h07, 8'h00, 8'h08, 0, 0);

    // Reset in the middle of WAIT
    send_req(4'h0, 2'b00, 8'h21, 8'h21, 8'h00, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    check("mr_alu_a", 32'(ALU_A), 32'd0);
    check("mr_alu_b", 32'(ALU_B), 32'd0);
    check("mr_instr", 32'(ALU_INSTRUCT), 32'd0);
    check("mr_valid", 32'(RSP_VALID), 32'd0);
    check("mr_ready", 32'(REQ_READY), 32'd0);
    check("mr_res", 32'(RSP_RESULT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("mr_norsp", 32'(RSP_VALID), 32'd0);
    end
    check("mr_idle", 32'(REQ_READY), 32'd1);
    run_op("mrch", 4'h0, 2'b00, 8'hFF, 8'h05, 8'h00, 1, 8'h00, 8'h00, 8'h05, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
